// File: rtl/vector_result_skid_buffer_if.sv
// -----------------------------------------------------------------------------
// vector_result_skid_buffer_if
// Handshake bundle between the vector ALU (upstream), the result skid buffer,
// and the memory/writeback stage (downstream).
//
// Signals:
//   in_valid / in_ready        upstream handshake
//   in_result [LANES][DW]      lane results
//   in_comparison [LANES]      per-lane less-than flags
//   in_dest [DEST_WIDTH]       destination vector register index
//   in_wr_en                   register-file write enable
//   out_valid / out_ready      downstream handshake
//   out_result, out_comparison, out_dest, out_wr_en   head entry fields
//
// Modports:
//   slave  - the buffer's view (accepts from upstream, presents downstream)
//   master - the environment's view (drives upstream, consumes downstream)
// -----------------------------------------------------------------------------
interface vector_result_skid_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 6,
  parameter int DEST_WIDTH = 4
);
  logic                                in_valid;
  logic                                in_ready;
  logic [LANES-1:0][DATA_WIDTH-1:0]    in_result;
  logic [LANES-1:0]                    in_comparison;
  logic [DEST_WIDTH-1:0]               in_dest;
  logic                                in_wr_en;

  logic                                out_valid;
  logic                                out_ready;
  logic [LANES-1:0][DATA_WIDTH-1:0]    out_result;
  logic [LANES-1:0]                    out_comparison;
  logic [DEST_WIDTH-1:0]               out_dest;
  logic                                out_wr_en;

  modport slave (
    input  in_valid, in_result, in_comparison, in_dest, in_wr_en, out_ready,
    output in_ready, out_valid, out_result, out_comparison, out_dest, out_wr_en
  );

  modport master (
    output in_valid, in_result, in_comparison, in_dest, in_wr_en, out_ready,
    input  in_ready, out_valid, out_result, out_comparison, out_dest, out_wr_en
  );
endinterface

// File: rtl/vector_result_skid_buffer.sv
// -----------------------------------------------------------------------------
// vector_result_skid_buffer
// Two-entry skid buffer between the vector ALU and the memory/writeback stage.
// MAIN is the head entry presented downstream; SKID catches the one entry that
// upstream may push while the downstream stage is stalling. in_ready comes
// straight from a flop so no combinational path exists from out_ready to
// in_ready.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   flush         synchronous flush, discards every buffered entry
//   bus           vector_result_skid_buffer_if.slave handshake bundle
//   stall_cycles  (only with VEC_SKID_STATS_EN) saturating 16-bit count of
//                 cycles with out_valid=1 and out_ready=0; not cleared by flush
//
// Optional feature macro: VEC_SKID_STATS_EN
// -----------------------------------------------------------------------------
module vector_result_skid_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 6,
  parameter int DEST_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  vector_result_skid_buffer_if.slave   bus
`ifdef VEC_SKID_STATS_EN
  ,
  output logic [15:0]                  stall_cycles
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    logic [LANES-1:0][DATA_WIDTH-1:0] result;
    logic [LANES-1:0]                 comparison;
    logic [DEST_WIDTH-1:0]            dest;
    logic                             wr_en;
  } entry_t;

  logic [1:0] state, state_d;
  logic       in_ready_q;
  entry_t     main_q, skid_q, in_entry;
  logic       in_xfer, out_xfer, out_valid;
  logic       load_main_in, load_main_skid, load_skid;

  assign in_entry  = {bus.in_result, bus.in_comparison, bus.in_dest, bus.in_wr_en};
  assign out_valid = (state != ST_EMPTY);
  assign in_xfer   = bus.in_valid & in_ready_q;
  assign out_xfer  = out_valid & bus.out_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Flush wins over everything; an input offered this cycle is dropped.
      state_d = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            load_main_in = 1'b1;
            state_d      = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_d   = ST_TWO;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so in_valid cannot cause a transfer.
          if (bus.out_ready) begin
            load_main_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the two data entries are reset too, because the out_* fields
      // must read 0 while reset is held, not just be marked invalid.
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state      <= state_d;
      // Registered from the next state: ready whenever a slot will be free.
      in_ready_q <= (state_d != ST_TWO);
      if (load_main_in) begin
        main_q <= in_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign {bus.out_result, bus.out_comparison, bus.out_dest, bus.out_wr_en} = main_q;

`ifdef VEC_SKID_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'd0;
    end else if (out_valid && !bus.out_ready && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vector_result_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_vector_result_skid_buffer
// Self-checking bench for vector_result_skid_buffer. The reference model is a
// FIFO of at most two entries: ready while fewer than two are held, valid
// while any is held, head shown on the outputs, flush empties it.
// Build with VEC_SKID_STATS_EN defined to also cover the stall counter.
// -----------------------------------------------------------------------------
module tb_vector_result_skid_buffer;
  localparam int DW   = 8;
  localparam int LN   = 6;
  localparam int DSTW = 4;
  localparam int EW   = LN*DW + LN + DSTW + 1;

  typedef logic [EW-1:0] ent_t;

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       ordy;
    logic       exp_ov;
    logic       exp_ir;
    logic [7:0] exp_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  vector_result_skid_buffer_if #(.DATA_WIDTH(DW), .LANES(LN), .DEST_WIDTH(DSTW)) bus ();

`ifdef VEC_SKID_STATS_EN
  logic [15:0] stall_cycles;
`endif

  vector_result_skid_buffer #(.DATA_WIDTH(DW), .LANES(LN), .DEST_WIDTH(DSTW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef VEC_SKID_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int   errors = 0;
  int   checks = 0;
  ent_t model_q[$];
  int   model_stall = 0;
  vec_t tbl[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [7:0] b);
    return {{LN{b}}, b[5:0], b[3:0], b[0]};
  endfunction

  function automatic ent_t rnd_ent();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[EW-1:0];
  endfunction

  function automatic ent_t dut_out();
    return {bus.out_result, bus.out_comparison, bus.out_dest, bus.out_wr_en};
  endfunction

  task automatic drive(input logic v, input ent_t e, input logic ordy, input logic fl);
    bus.in_valid = v;
    {bus.in_result, bus.in_comparison, bus.in_dest, bus.in_wr_en} = e;
    bus.out_ready = ordy;
    flush = fl;
  endtask

  // One clock: compare at the falling edge, then advance the model across the
  // rising edge using the inputs that were presented.
  task automatic cycle();
    bit   pop, push, fl;
    ent_t e;
    @(negedge clk);
    check("out_valid", bus.out_valid, model_q.size() > 0);
    check("in_ready", bus.in_ready, model_q.size() < 2);
    if (model_q.size() > 0) check("out_data", dut_out(), model_q[0]);
`ifdef VEC_SKID_STATS_EN
    check("stall_cycles", stall_cycles, model_stall);
`endif
    pop  = (model_q.size() > 0) && bus.out_ready;
    push = bus.in_valid && (model_q.size() < 2);
    fl   = flush;
    e    = {bus.in_result, bus.in_comparison, bus.in_dest, bus.in_wr_en};
    if ((model_q.size() > 0) && !bus.out_ready && (model_stall < 65535)) model_stall++;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back(e);
    end
    #1;
  endtask

  initial begin
    // Directed sequence: single pass-through, then A/B/C with a stalled sink.
    tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[3] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[4] = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 8'hA1};
    tbl[5] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 8'hA1};
    tbl[6] = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 8'hA1};
    tbl[7] = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 8'hB2};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC3};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};

    // Reset: outputs must settle to their reset values while rst is held.
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #3;
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_out_data", dut_out(), '0);
`ifdef VEC_SKID_STATS_EN
    check("reset_stall", stall_cycles, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    model_stall = 0;

    // Table-driven directed vectors.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, mk(tbl[i].b), tbl[i].ordy, 1'b0);
      check($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].exp_ov);
      check($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].exp_ir);
      if (tbl[i].exp_ov) check($sformatf("tbl%0d_out_data", i), dut_out(), mk(tbl[i].exp_b));
      cycle();
    end

    // Streaming in ONE: push and pop every cycle for 20 cycles.
    drive(1'b1, mk(8'h40), 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, rnd_ent(), 1'b1, 1'b0);
      check("stream_in_ready", bus.in_ready, 1'b1);
      check("stream_out_valid", bus.out_valid, 1'b1);
      cycle();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();

    // Flush from TWO while an entry is offered: it must be dropped.
    drive(1'b1, mk(8'hD1), 1'b0, 1'b0);
    cycle();
    drive(1'b1, mk(8'hD2), 1'b0, 1'b0);
    cycle();
    drive(1'b1, mk(8'hEE), 1'b0, 1'b1);
    cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_in_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < 3; i++) cycle();

    // Asynchronous reset mid-cycle while holding two entries.
    drive(1'b1, mk(8'h5A), 1'b0, 1'b0);
    cycle();
    drive(1'b1, mk(8'hA5), 1'b0, 1'b0);
    cycle();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", bus.out_valid, 1'b0);
    check("async_rst_in_ready", bus.in_ready, 1'b1);
    check("async_rst_out_data", dut_out(), '0);
    rst = 1'b0;
    model_q.delete();
    model_stall = 0;
    // First edge after release must accept an entry.
    drive(1'b1, mk(8'h77), 1'b1, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_accept", bus.out_valid, 1'b1);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, rnd_ent(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      cycle();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    cycle();

`ifdef VEC_SKID_STATS_EN
    // Long stall: counter saturates, and flush leaves it alone.
    drive(1'b1, mk(8'h3C), 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    model_stall = 65535;
    check("stall_saturated", stall_cycles, 16'hFFFF);
    drive(1'b0, '0, 1'b0, 1'b1);
    cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    check("stall_after_flush", stall_cycles, 16'hFFFF);
    cycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
